// File: rtl/scudsp_dma_ctrl_pkg.sv
// Shared SCU DSP definitions: DMA instruction fields, sequencer states and the
// count/increment decode rules used by both the decoder and the DMA sequencer.
package scudsp_dma_ctrl_pkg;

  localparam int INC_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT,
    ST_RD,
    ST_BUS,
    ST_FIN
  } dma_state_e;

  typedef struct packed {
    logic       dir;
    logic [3:0] ramw;
    logic       prgw;
    logic [1:0] rams;
    logic [2:0] addi;
    logic       cntm;
    logic [1:0] cnts;
    logic       hold;
    logic [7:0] imm8;
  } dma_instr_t;

  // Reads from RAM only support a unit step; writes into RAM use a power-of-two table.
  function automatic logic [INC_W-1:0] dma_inc(input logic dir, input logic [2:0] addi);
    if (dir) begin
      return (addi == 3'd1) ? 6'd1 : 6'd0;
    end
    if (addi < 3'd2) begin
      return 6'd0;
    end
    return 6'd1 << (addi - 3'd2);
  endfunction

  function automatic logic [8:0] dma_count(input logic [7:0] raw);
    return (raw == 8'd0) ? 9'd256 : {1'b0, raw};
  endfunction

endpackage

// File: rtl/scudsp_dma_ctrl.sv
// SCU DSP DMA sequencer: moves 32-bit words between the D0 bus and DSP data or
// program RAM for one decoded DMA instruction, then writes back RA0/WA0.
module scudsp_dma_ctrl
  import scudsp_dma_ctrl_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [3:0]        ramw,
  input  logic              prgw,
  input  logic [1:0]        rams,
  input  logic [2:0]        addi,
  input  logic              cntm,
  input  logic [1:0]        cnts,
  input  logic              hold,
  input  logic [7:0]        imm8,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [31:0]       ram_rdata,
  output logic              ram_rd,
  output logic [1:0]        ram_sel,
  output logic [3:0]        ram_we,
  output logic              prg_we,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ct_inc,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              ra0_we,
  output logic              wa0_we,
  output logic [ADDR_W-1:0] addr_out
);

  dma_instr_t  ins;
  dma_state_e  state, state_d;

  logic              dir_q, prgw_q, hold_q, wait_q;
  logic [3:0]        ramw_q;
  logic [1:0]        rams_q;
  logic [INC_W-1:0]  inc_q;
  logic [ADDR_W-1:0] addr_q, addr_next, launch_addr;
  logic [8:0]        count_q;
  logic              accept, launch, ack_ok, launch_dir;
  logic [1:0]        launch_rams;

  assign ins = '{dir: dir, ramw: ramw, prgw: prgw, rams: rams, addi: addi,
                 cntm: cntm, cnts: cnts, hold: hold, imm8: imm8};

  assign addr_next = addr_q + ADDR_W'(inc_q);

  // A beat can start straight from a START (fields not latched yet) or from an ACK.
  assign launch_dir  = accept ? ins.dir  : dir_q;
  assign launch_rams = accept ? ins.rams : rams_q;
  assign launch_addr = accept ? (ins.dir ? wa0 : ra0) : (ack_ok ? addr_next : addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state;
    accept  = 1'b0;
    launch  = 1'b0;
    ack_ok  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (ins.cntm) begin
            state_d = ST_CNT;
          end else begin
            launch  = 1'b1;
            state_d = ins.dir ? ST_RD : ST_BUS;
          end
        end
      end
      ST_CNT: begin
        if (wait_q) begin
          launch  = 1'b1;
          state_d = dir_q ? ST_RD : ST_BUS;
        end
      end
      ST_RD: begin
        if (wait_q) state_d = ST_BUS;
      end
      ST_BUS: begin
        if (bus_req && bus_ack) begin
          ack_ok = 1'b1;
          if (count_q == 9'd1) begin
            state_d = ST_FIN;
          end else begin
            launch  = 1'b1;
            state_d = dir_q ? ST_RD : ST_BUS;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; later branches
  // deliberately override earlier ones within the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q     <= 1'b0;
      prgw_q    <= 1'b0;
      hold_q    <= 1'b0;
      wait_q    <= 1'b0;
      ramw_q    <= '0;
      rams_q    <= '0;
      inc_q     <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      ram_rd    <= 1'b0;
      ram_sel   <= '0;
      ram_we    <= '0;
      prg_we    <= 1'b0;
      ram_wdata <= '0;
      ct_inc    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      busy      <= 1'b0;
      ra0_we    <= 1'b0;
      wa0_we    <= 1'b0;
      addr_out  <= '0;
    end else begin
      ram_rd <= 1'b0;
      ram_we <= '0;
      prg_we <= 1'b0;
      ct_inc <= '0;
      ra0_we <= 1'b0;
      wa0_we <= 1'b0;

      if (accept) begin
        dir_q   <= ins.dir;
        ramw_q  <= ins.ramw;
        prgw_q  <= ins.prgw;
        rams_q  <= ins.rams;
        hold_q  <= ins.hold;
        inc_q   <= dma_inc(ins.dir, ins.addi);
        addr_q  <= launch_addr;
        count_q <= dma_count(ins.imm8);
        busy    <= 1'b1;
        if (ins.cntm) begin
          ram_rd  <= 1'b1;
          ram_sel <= ins.cnts;
          wait_q  <= 1'b0;
        end
      end

      // Count fetch and RAM read take two cycles: strobe, then capture the data.
      if (state == ST_CNT) begin
        if (wait_q) count_q <= dma_count(ram_rdata[7:0]);
        wait_q <= ~wait_q;
      end

      if (state == ST_RD) begin
        if (wait_q) begin
          bus_req   <= 1'b1;
          bus_we    <= 1'b1;
          bus_addr  <= addr_q;
          bus_wdata <= ram_rdata;
        end
        wait_q <= ~wait_q;
      end

      if (ack_ok) begin
        bus_req <= 1'b0;
        addr_q  <= addr_next;
        count_q <= count_q - 9'd1;
        if (!dir_q) begin
          ram_wdata <= bus_rdata;
          ram_we    <= prgw_q ? 4'b0000 : ramw_q;
          prg_we    <= prgw_q;
          ct_inc    <= prgw_q ? 4'b0000 : ramw_q;
        end
        if (count_q == 9'd1 && !hold_q) begin
          ra0_we   <= ~dir_q;
          wa0_we   <= dir_q;
          addr_out <= addr_next;
        end
      end

      if (launch) begin
        if (launch_dir) begin
          ram_rd  <= 1'b1;
          ram_sel <= launch_rams;
          ct_inc  <= 4'b0001 << launch_rams;
          wait_q  <= 1'b0;
        end else begin
          bus_req  <= 1'b1;
          bus_we   <= 1'b0;
          bus_addr <= launch_addr;
        end
      end

      if (state == ST_FIN) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scudsp_dma_ctrl.sv
// Self-checking bench for scudsp_dma_ctrl: directed and randomized DMA
// instructions against a transaction-level model of the expected transfer.
module tb_scudsp_dma_ctrl;

  localparam int ADDR_W = 25;
  localparam int unsigned INC_DIR0 [8] = '{0, 0, 1, 2, 4, 8, 16, 32};

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
  } bus_txn_t;

  typedef struct {
    logic [3:0]  we;
    logic        prg;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, dir = 1'b0, prgw = 1'b0, cntm = 1'b0, hold = 1'b0;
  logic [3:0] ramw = '0;
  logic [1:0] rams = '0, cnts = '0;
  logic [2:0] addi = '0;
  logic [7:0] imm8 = '0;
  logic [ADDR_W-1:0] ra0 = '0, wa0 = '0;
  logic [31:0] ram_rdata = '0;
  logic [31:0] bus_rdata;
  logic bus_ack;

  logic ram_rd, prg_we, bus_req, bus_we, busy, ra0_we, wa0_we;
  logic [1:0] ram_sel;
  logic [3:0] ram_we, ct_inc;
  logic [31:0] ram_wdata, bus_wdata;
  logic [ADDR_W-1:0] bus_addr, addr_out;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [4][1024];
  int rd_cnt [4] = '{0, 0, 0, 0};
  bus_txn_t bus_log [$];
  wr_t wr_log [$];
  int ct_tot [4] = '{0, 0, 0, 0};
  int ra0_n = 0, wa0_n = 0;
  logic [ADDR_W-1:0] ra0_v = '0, wa0_v = '0;
  int stray_req = 0, stray_done = 0;

  scudsp_dma_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .ramw(ramw), .prgw(prgw),
    .rams(rams), .addi(addi), .cntm(cntm), .cnts(cnts), .hold(hold), .imm8(imm8),
    .ra0(ra0), .wa0(wa0), .ram_rdata(ram_rdata), .ram_rd(ram_rd), .ram_sel(ram_sel),
    .ram_we(ram_we), .prg_we(prg_we), .ram_wdata(ram_wdata), .ct_inc(ct_inc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .ra0_we(ra0_we),
    .wa0_we(wa0_we), .addr_out(addr_out)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Data RAM: each read returns the next word of that bank's stream, one cycle later.
  initial begin
    int b;
    forever begin
      @(negedge clk);
      if (ram_rd && !rst) begin
        b = int'(ram_sel);
        @(posedge clk);
        #1;
        ram_rdata = mem[b][rd_cnt[b] % 1024];
        rd_cnt[b]++;
      end
    end
  end

  // D0 bus slave with a random 0..2 cycle wait, plus optional stray acks.
  initial begin
    int wcnt, dly;
    wcnt = 0;
    dly = 1;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_ack) begin
        bus_ack = 1'b0;
      end else if (stray_req != stray_done) begin
        stray_done = stray_req;
        bus_ack = 1'b1;
        bus_rdata = $urandom;
      end else if (bus_req && !rst) begin
        if (wcnt >= dly) begin
          bus_ack = 1'b1;
          bus_rdata = $urandom;
          bus_log.push_back('{bus_addr, bus_we, bus_wdata, bus_rdata});
          wcnt = 0;
          dly = int'($urandom_range(0, 2));
        end else begin
          wcnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ram_we != 4'b0000 || prg_we) wr_log.push_back('{ram_we, prg_we, ram_wdata});
      for (int b = 0; b < 4; b++) if (ct_inc[b]) ct_tot[b]++;
      if (ra0_we) begin ra0_n++; ra0_v = addr_out; end
      if (wa0_we) begin wa0_n++; wa0_v = addr_out; end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    dir  = 1'($urandom);
    ramw = 4'($urandom);
    prgw = 1'($urandom);
    rams = 2'($urandom);
    addi = 3'($urandom);
    cntm = 1'($urandom);
    cnts = 2'($urandom);
    hold = 1'($urandom);
    imm8 = 8'($urandom);
    ra0  = ADDR_W'($urandom);
    wa0  = ADDR_W'($urandom);
  endtask

  task automatic run_dma(input string nm, input logic d, input logic [3:0] rw, input logic pw,
                         input logic [1:0] rs, input logic [2:0] ad, input logic cm,
                         input logic [1:0] cs, input logic hd, input logic [7:0] im,
                         input logic [ADDR_W-1:0] a0, input logic [7:0] cw, input bit poke);
    int n, inc, bus0, wr0, base, nb, nw, ra0n0, wa0n0;
    int ct0 [4];
    bit done;
    logic [31:0] tmp;
    logic [ADDR_W-1:0] ea;
    bus_txn_t t;
    wr_t w;

    @(negedge clk);
    check({nm, ":idle_before"}, busy, 0);
    n   = cm ? ((cw == 0) ? 256 : int'(cw)) : ((im == 0) ? 256 : int'(im));
    inc = d ? ((ad == 3'd1) ? 1 : 0) : int'(INC_DIR0[ad]);
    if (cm) begin
      tmp = $urandom;
      tmp[7:0] = cw;
      mem[cs][rd_cnt[cs] % 1024] = tmp;
    end
    base  = rd_cnt[rs] + ((cm && cs == rs) ? 1 : 0);
    bus0  = bus_log.size();
    wr0   = wr_log.size();
    ra0n0 = ra0_n;
    wa0n0 = wa0_n;
    for (int b = 0; b < 4; b++) ct0[b] = ct_tot[b];

    dir = d; ramw = rw; prgw = pw; rams = rs; addi = ad; cntm = cm; cnts = cs;
    hold = hd; imm8 = im;
    if (d) begin wa0 = a0; ra0 = ~a0; end
    else   begin ra0 = a0; wa0 = ~a0; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    check({nm, ":busy_rise"}, busy, 1);

    done = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) begin done = 1'b1; break; end
      if (poke && cyc == 2) start = 1'b1;
    end
    start = 1'b0;
    check({nm, ":completed"}, done, 1);
    if (!done) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    repeat (2) @(negedge clk);

    nb = bus_log.size() - bus0;
    check({nm, ":beats"}, nb, n);
    for (int i = 0; i < n && i < nb; i++) begin
      t  = bus_log[bus0 + i];
      ea = a0 + ADDR_W'(i * inc);
      check($sformatf("%s:addr[%0d]", nm, i), t.addr, ea);
      check($sformatf("%s:we[%0d]", nm, i), t.we, d);
      if (d) check($sformatf("%s:wdata[%0d]", nm, i), t.wdata, mem[rs][(base + i) % 1024]);
    end

    nw = wr_log.size() - wr0;
    check({nm, ":ram_writes"}, nw, d ? 0 : n);
    for (int i = 0; i < nw && i < nb && !d; i++) begin
      w = wr_log[wr0 + i];
      check($sformatf("%s:ram_we[%0d]", nm, i), w.we, pw ? 4'b0000 : rw);
      check($sformatf("%s:prg_we[%0d]", nm, i), w.prg, pw);
      check($sformatf("%s:ram_wdata[%0d]", nm, i), w.data, bus_log[bus0 + i].rdata);
    end

    for (int b = 0; b < 4; b++) begin
      check($sformatf("%s:ct_inc[%0d]", nm, b), ct_tot[b] - ct0[b],
            d ? ((b == int'(rs)) ? n : 0) : ((!pw && rw[b]) ? n : 0));
    end

    ea = a0 + ADDR_W'(n * inc);
    check({nm, ":ra0_we"}, ra0_n - ra0n0, (!hd && !d) ? 1 : 0);
    check({nm, ":wa0_we"}, wa0_n - wa0n0, (!hd && d) ? 1 : 0);
    if (!hd && !d) check({nm, ":ra0_val"}, ra0_v, ea);
    if (!hd && d)  check({nm, ":wa0_val"}, wa0_v, ea);
  endtask

  initial begin
    logic d, pw, cm, hd;
    logic [3:0] rw;
    logic [1:0] rs, cs;
    logic [2:0] ad;
    logic [7:0] im, cw;
    int wr0, ra0n0, wa0n0, ct00;
    bit got_req;

    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 1024; i++) mem[b][i] = $urandom;

    @(negedge clk);
    check("reset:busy", busy, 0);
    check("reset:bus_req", bus_req, 0);
    check("reset:bus_addr", bus_addr, 0);
    check("reset:bus_wdata", bus_wdata, 0);
    check("reset:ram_wdata", ram_wdata, 0);
    check("reset:addr_out", addr_out, 0);
    check("reset:strobes", {ram_rd, ram_we, prg_we, ct_inc, ra0_we, wa0_we}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_dma("d0_basic", 1'b0, 4'b0001, 1'b0, 2'd0, 3'd2, 1'b0, 2'd0, 1'b0, 8'd3,
            25'h0000100, 8'd0, 1'b0);
    run_dma("d1_wrap", 1'b1, 4'b0000, 1'b0, 2'd2, 3'd1, 1'b1, 2'd1, 1'b0, 8'd0,
            25'h1FFFFFF, 8'd2, 1'b0);
    run_dma("prg_256", 1'b0, 4'b0000, 1'b1, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 8'd0,
            25'h0ABCDE0, 8'd0, 1'b0);
    run_dma("hold_step32", 1'b0, 4'b0100, 1'b0, 2'd0, 3'd7, 1'b0, 2'd0, 1'b1, 8'd5,
            25'h1FFFFC0, 8'd0, 1'b0);
    run_dma("start_busy", 1'b1, 4'b0000, 1'b0, 2'd3, 3'd0, 1'b0, 2'd0, 1'b0, 8'd4,
            25'h0123456, 8'd0, 1'b1);

    // Asynchronous reset in the middle of an outstanding bus request.
    @(negedge clk);
    dir = 1'b0; ramw = 4'b0010; prgw = 1'b0; addi = 3'd2; cntm = 1'b0; hold = 1'b0;
    imm8 = 8'd20; ra0 = 25'h0000055;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus_req) begin got_req = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_mid:req_seen", got_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid:busy", busy, 0);
    check("rst_mid:bus_req", bus_req, 0);
    check("rst_mid:bus_addr", bus_addr, 0);
    check("rst_mid:bus_we", bus_we, 0);
    check("rst_mid:addr_out", addr_out, 0);
    check("rst_mid:strobes", {ram_rd, ram_we, prg_we, ct_inc, ra0_we, wa0_we}, 0);
    wr0 = wr_log.size();
    ra0n0 = ra0_n;
    wa0n0 = wa0_n;
    ct00 = ct_tot[1];
    @(negedge clk);
    rst = 1'b0;
    stray_req++;
    repeat (4) @(negedge clk);
    check("rst_mid:busy_after", busy, 0);
    check("rst_mid:req_after", bus_req, 0);
    check("rst_mid:no_write", wr_log.size() - wr0, 0);
    check("rst_mid:no_ct", ct_tot[1] - ct00, 0);
    check("rst_mid:no_wb", (ra0_n - ra0n0) + (wa0_n - wa0n0), 0);

    run_dma("after_rst", 1'b0, 4'b1000, 1'b0, 2'd0, 3'd3, 1'b0, 2'd0, 1'b0, 8'd4,
            25'h0000200, 8'd0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      d  = 1'($urandom);
      pw = !d && ($urandom_range(0, 3) == 0);
      rw = pw ? 4'b0000 : (4'b0001 << $urandom_range(0, 3));
      rs = 2'($urandom);
      ad = 3'($urandom);
      cm = 1'($urandom);
      cs = 2'($urandom);
      hd = 1'($urandom);
      im = 8'($urandom_range(1, 8));
      cw = 8'($urandom_range(1, 8));
      run_dma($sformatf("rand%0d", r), d, rw, pw, rs, ad, cm, cs, hd, im,
              ADDR_W'($urandom), cw, r == 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
